// File: rtl/sr_chain_sequencer.sv
// Sequencer for the two-phase latch shift-register chain: non-overlapping phi1/phi2, byte serdes.
// Compile with SR_SEQ_FLUSH_EN defined to append CHAIN_LEN/2 zero-input flush steps to every run.
module sr_chain_sequencer #(
    parameter int unsigned CHAIN_LEN = 128,
    parameter int unsigned GAP       = 1,
    parameter int unsigned CNT_W     = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             phi1,
    output logic             phi2,
    output logic             sr_in,
    input  logic             sr_out,
    output logic             busy,
    output logic             done
);
    localparam int unsigned      GAP_W       = 3;
    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'((GAP == 0) ? 0 : GAP - 1);
    localparam logic [CNT_W-1:0] FLUSH_STEPS = CNT_W'(CHAIN_LEN / 2);
`ifdef SR_SEQ_FLUSH_EN
    localparam logic FLUSH_EN = 1'b1;
`else
    localparam logic FLUSH_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, SETUP, PH1, GAP1, PH2, GAP2, SAMPLE} state_t;

    state_t           state, state_n;
    logic [2:0]       idx, idx_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [7:0]       tx_byte, tx_byte_n;
    logic [7:0]       rx_sh, rx_sh_n;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
    logic             flushing, flushing_n;
    logic             sr_in_n, rx_valid_n, done_n, last;
    logic [7:0]       rx_data_n;

    // Next-state, datapath and registered-output values
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        cnt_n      = cnt;
        tx_byte_n  = tx_byte;
        rx_sh_n    = rx_sh;
        gap_cnt_n  = gap_cnt;
        flushing_n = flushing;
        sr_in_n    = sr_in;
        rx_data_n  = rx_data;
        rx_valid_n = 1'b0;
        done_n     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                // done high means a run just ended; a start in that cycle is dropped
                if (start && !done) begin
                    if (len != '0) begin
                        state_n    = LOAD;
                        cnt_n      = len;
                        idx_n      = '0;
                        rx_sh_n    = '0;
                        flushing_n = 1'b0;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (tx_valid) begin
                    tx_byte_n = tx_data;
                    sr_in_n   = tx_data[idx];
                    state_n   = SETUP;
                end
            end
            SETUP: state_n = PH1;
            PH1: begin
                gap_cnt_n = '0;
                state_n   = (GAP == 0) ? PH2 : GAP1;
            end
            GAP1: begin
                gap_cnt_n = gap_cnt + GAP_W'(1);
                if (gap_cnt == GAP_LAST) state_n = PH2;
            end
            PH2: begin
                gap_cnt_n = '0;
                state_n   = (GAP == 0) ? SAMPLE : GAP2;
            end
            GAP2: begin
                gap_cnt_n = gap_cnt + GAP_W'(1);
                if (gap_cnt == GAP_LAST) state_n = SAMPLE;
            end
            SAMPLE: begin
                rx_sh_n[idx] = sr_out;
                idx_n        = idx + 3'd1;
                cnt_n        = cnt - CNT_W'(1);
                last         = (cnt == CNT_W'(1));
                // End of programmed steps rolls into the flush phase instead of finishing
                if (FLUSH_EN && last && !flushing) begin
                    last       = 1'b0;
                    flushing_n = 1'b1;
                    cnt_n      = FLUSH_STEPS;
                end
                if (idx == 3'd7 || last) begin
                    rx_valid_n = 1'b1;
                    rx_data_n  = rx_sh_n;
                    rx_sh_n    = '0;
                end
                if (last) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else if (idx_n == 3'd0 && !flushing_n) begin
                    state_n = LOAD;
                end else begin
                    state_n = SETUP;
                    sr_in_n = flushing_n ? 1'b0 : tx_byte[idx_n];
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; phases decode from a single next state so they never overlap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            tx_byte  <= '0;
            rx_sh    <= '0;
            gap_cnt  <= '0;
            flushing <= 1'b0;
            phi1     <= 1'b0;
            phi2     <= 1'b0;
            sr_in    <= 1'b0;
            tx_ready <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            cnt      <= cnt_n;
            tx_byte  <= tx_byte_n;
            rx_sh    <= rx_sh_n;
            gap_cnt  <= gap_cnt_n;
            flushing <= flushing_n;
            phi1     <= (state_n == PH1);
            phi2     <= (state_n == PH2);
            sr_in    <= sr_in_n;
            tx_ready <= (state_n == LOAD);
            rx_data  <= rx_data_n;
            rx_valid <= rx_valid_n;
            busy     <= (state_n != IDLE);
            done     <= done_n;
        end
    end
endmodule

// File: tb/tb_sr_chain_sequencer.sv
// Scoreboard bench for sr_chain_sequencer: behavioural latch chain plus a bit-queue reference model.
`timescale 1ns/1ps
module tb_sr_chain_sequencer;
    localparam int unsigned CHAIN_LEN = 128;
    localparam int unsigned GAP       = 1;
    localparam int unsigned CNT_W     = 12;
    localparam int          STEP      = 4 + 2 * GAP;
    localparam int          DEPTH     = CHAIN_LEN / 2;
`ifdef SR_SEQ_FLUSH_EN
    localparam int          FLUSH     = DEPTH;
`else
    localparam int          FLUSH     = 0;
`endif

    logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0, tx_valid = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic [7:0]       tx_data = '0;
    logic             tx_ready, rx_valid, phi1, phi2, sr_in, busy, done;
    logic [7:0]       rx_data;
    logic             sr_out = 1'b0;

    sr_chain_sequencer #(.CHAIN_LEN(CHAIN_LEN), .GAP(GAP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .phi1(phi1), .phi2(phi2), .sr_in(sr_in), .sr_out(sr_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Chain environment: phi1 captures the input, phi2 advances the DEPTH-step pipe
    logic [DEPTH-1:0] chain = '0;
    logic cap = 1'b0, fill_req = 1'b0, fill_val = 1'b0;
    always @(posedge clk) begin
        if (fill_req) chain <= {DEPTH{fill_val}};
        else begin
            if (phi1) cap <= sr_in;
            if (phi2) begin
                sr_out <= chain[DEPTH-1];
                chain  <= {chain[DEPTH-2:0], cap};
            end
        end
    end

    typedef struct { logic [7:0] data; bit has_rx; bit last; } exp_t;
    exp_t       exp_q[$];
    exp_t       mon_e;
    bit         pipe[$];
    logic [7:0] tx_bytes [0:15];
    int         n_cmp = 0, n_bad = 0;
    logic       sr_hold = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [14:0] outs();
        return {phi1, phi2, sr_in, tx_ready, rx_valid, busy, done, rx_data};
    endfunction

    // Monitor: pops one expectation per rx_valid/done strobe
    always @(negedge clk) begin
        n_cmp++;
        assert (!(phi1 && phi2)) else begin
            n_bad++;
            $display("FAIL phase_overlap: phi1=%b phi2=%b, want never both (t=%0t)", phi1, phi2, $time);
        end
        if (phi1) sr_hold <= sr_in;
        if (phi2) check("sr_in_stable_ph1_ph2", 32'(sr_in), 32'(sr_hold));
        if (rx_valid || done) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_strobe: rx_valid=%b done=%b rx_data=%02h, want none (t=%0t)",
                         rx_valid, done, rx_data, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("rx_valid", 32'(rx_valid), 32'(mon_e.has_rx));
                check("done_with_last", 32'(done), 32'(mon_e.last));
                if (mon_e.has_rx) check("rx_data", 32'(rx_data), 32'(mon_e.data));
            end
        end
    end

    task automatic fill(input logic v);
        fill_val = v; fill_req = 1'b1;
        @(posedge clk); #1;
        fill_req = 1'b0;
        pipe.delete();
        repeat (DEPTH) pipe.push_back(v);
    endtask

    // One run: model the bit stream through the chain, then drive and count pulses/handshakes
    task automatic run(input int n, input int stall_byte, input int stall_cyc, input bit chk_lat);
        int total, nbytes, cyc, hs, p1, p2, stall, t_hs, t_done, quiet, bound;
        bit got, ib, ob;
        logic [7:0] acc, b;
        exp_t e;
        total  = (n == 0) ? 0 : n + FLUSH;
        nbytes = (n + 7) / 8;
        acc    = '0;
        for (int s = 0; s < total; s++) begin
            ib = 1'b0;
            if (s < n) begin b = tx_bytes[s / 8]; ib = b[s % 8]; end
            ob = pipe.pop_front();
            pipe.push_back(ib);
            acc[s % 8] = ob;
            if (s % 8 == 7 || s == total - 1) begin
                e.data = acc; e.has_rx = 1'b1; e.last = (s == total - 1);
                exp_q.push_back(e);
                acc = '0;
            end
        end
        if (n == 0) begin e.data = '0; e.has_rx = 1'b0; e.last = 1'b1; exp_q.push_back(e); end

        start = 1'b1; len = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; hs = 0; p1 = 0; p2 = 0; stall = 0; got = 1'b0; t_hs = 0; t_done = 0; quiet = 0;
        bound = total * STEP + nbytes * (stall_cyc + 2) + 20;
        while (!got && cyc < bound) begin
            start = (cyc == 2);
            len   = CNT_W'(3);
            if (tx_ready) begin
                if (hs == stall_byte && stall < stall_cyc) begin
                    tx_valid = 1'b0; stall++;
                    if (phi1 || phi2) quiet++;
                end else begin
                    tx_valid = 1'b1; tx_data = tx_bytes[hs % 16]; t_hs = cyc; hs++;
                end
            end else tx_valid = 1'b0;
            if (phi1) p1++;
            if (phi2) p2++;
            if (done) begin got = 1'b1; t_done = cyc; start = 1'b1; len = CNT_W'(5); end
            @(posedge clk); #1;
            cyc++;
        end
        check("busy_after_done_start_ignored", 32'(busy), 32'(0));
        start = 1'b0; tx_valid = 1'b0;
        check("done_seen", 32'(got), 32'(1));
        check("tx_handshakes", 32'(hs), 32'(nbytes));
        check("phi1_pulses", 32'(p1), 32'(total));
        check("phi2_pulses", 32'(p2), 32'(total));
        if (stall_cyc > 0) check("phases_quiet_in_stall", 32'(quiet), 32'(0));
        if (chk_lat) check("done_latency", 32'(t_done - t_hs), 32'((total - 8 * (nbytes - 1)) * STEP + 1));
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic reset_mid_run();
        int p1, cyc;
        p1 = 0; cyc = 0;
        start = 1'b1; len = CNT_W'(40); tx_data = 8'h5A;
        @(posedge clk); #1;
        start = 1'b0;
        while (p1 < 5 && cyc < 200) begin
            tx_valid = tx_ready;
            if (phi1) p1++;
            if (p1 < 5) begin @(posedge clk); #1; cyc++; end
        end
        check("reached_ph1_of_step5", 32'(p1), 32'(5));
        check("phi1_high_at_reset", 32'(phi1), 32'(1));
        rst_n = 1'b0; tx_valid = 1'b0;
        @(posedge clk); #1;
        check("outputs_after_midrun_reset", 32'(outs()), 32'(0));
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("idle_after_midrun_reset", 32'(outs()), 32'(0));
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) tx_bytes[i] = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'(outs()), 32'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("idle_outputs", 32'(outs()), 32'(0));
        end

        fill(1'b0); tx_bytes[0] = 8'hA5;
        run(8, -1, 0, 1'b1);

        fill(1'b0); tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h3C;
        for (int i = 2; i < 9; i++) tx_bytes[i] = 8'h00;
        run(72, -1, 0, 1'b1);

        fill(1'b0); tx_bytes[0] = 8'h96; tx_bytes[1] = 8'h4E; tx_bytes[2] = 8'hD1;
        run(24, -1, 0, 1'b1);
        fill(1'b0);
        run(24, 1, 10, 1'b1);

        fill(1'b1); tx_bytes[0] = 8'hFF;
        run(3, -1, 0, 1'b1);
        run(0, -1, 0, 1'b0);

        reset_mid_run();
        fill(1'b0);

        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, 60));
            for (int i = 0; i < 16; i++) tx_bytes[i] = 8'($urandom);
            run(n, int'($urandom_range(0, (n - 1) / 8)), int'($urandom_range(0, 4)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
